// File: rtl/store_log_pkg.sv
// Shared types and default constants for the store event logger.
package store_log_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_TS_W  = 16;
    localparam int DEF_SEQ_W = 10;

    // Ceiling of the saturating drop counter.
    localparam logic [7:0] DROP_SAT = 8'd255;

    // One logged store event at the default widths.
    typedef struct packed {
        logic [DEF_TS_W-1:0]  ts;
        logic [DEF_SEQ_W-1:0] seq;
    } store_evt_t;

endpackage

// File: rtl/store_log_fifo.sv
// Single-clock FIFO of event records with push/pop/level.
// The caller gates push/pop: pop only when non-empty, push only when not
// full or together with a pop. A full FIFO with push and pop on the same
// edge writes into the slot being vacated, so the level stays at DEPTH.
module store_log_fifo
    import store_log_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    parameter type T     = store_evt_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  T                       data_i,
    output T                       head_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;

    // Next occupancy: push adds one, pop removes one, both leave it unchanged.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        level_d = level_q;
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointers and level; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            level_q <= level_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately not reset; validity is tracked by level_q alone.
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LVL_FULL);

endmodule

// File: rtl/store_event_logger.sv
// Timestamps and sequence-numbers each sampled store strobe, buffers the
// records in a FIFO and presents them over a valid/ready port.
// Optional feature macro: STORE_LOG_DROP_CNT_EN enables the saturating
// drop counter; without it drop_count is tied to zero and drops show up
// only as gaps in evt_seq.
module store_event_logger
    import store_log_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int TS_W  = DEF_TS_W,
    parameter int SEQ_W = DEF_SEQ_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   store_i,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [TS_W-1:0]        evt_ts,
    output logic [SEQ_W-1:0]       evt_seq,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             drop_count
);

    // Record at this instance's widths.
    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [SEQ_W-1:0] seq;
    } evt_t;

    localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
    localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

    logic [TS_W-1:0]  ts_q;
    logic [TS_W-1:0]  ts_d;
    logic [SEQ_W-1:0] seq_q;
    logic [SEQ_W-1:0] seq_d;
    logic             fifo_full;
    logic             push;
    logic             pop;
    evt_t             new_evt;
    evt_t             head;

    // Timestamp free-runs; sequence advances on every event, kept or dropped.
    always_comb begin
        ts_d  = ts_q + TS_ONE;
        seq_d = seq_q;
        if (store_i) seq_d = seq_q + SEQ_ONE;
    end

    // Timestamp and sequence counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q  <= '0;
            seq_q <= '0;
        end else begin
            ts_q  <= ts_d;
            seq_q <= seq_d;
        end
    end

    // Records carry the counter values from before this edge's increment.
    assign new_evt = '{ts: ts_q, seq: seq_q};

    assign evt_valid = (fifo_level != '0);
    assign pop       = evt_valid & evt_ready;
    assign push      = store_i & (~fifo_full | pop);

    store_log_fifo #(
        .DEPTH (DEPTH),
        .T     (evt_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (new_evt),
        .head_o  (head),
        .level_o (fifo_level),
        .full_o  (fifo_full)
    );

    // Head fields read zero when empty, which also gives clean reset values.
    assign evt_ts  = evt_valid ? head.ts  : '0;
    assign evt_seq = evt_valid ? head.seq : '0;

`ifdef STORE_LOG_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_cnt_q;
    logic [7:0] drop_cnt_d;

    assign drop = store_i & fifo_full & ~pop;

    // Count drops, holding at the ceiling.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != DROP_SAT)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: doc/store_event_logger.md
# store_event_logger

Downstream consumer of the user-counting FSM's store strobe `y`. It timestamps every store event against a free-running cycle counter and tags it with a sequence number. Events are buffered in a small FIFO and drained by a host-side reader over a valid/ready handshake. Drops caused by a full FIFO are counted and remain visible as gaps in the sequence numbers.

## Interface
- `DEPTH`, default 8: FIFO entries; a power of two, ≥ 2.
- `TS_W`, default 16: timestamp width.
- `SEQ_W`, default 10: sequence-number width; matches the 10-bit `users_count`.
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `store_i`, in, 1: store strobe from the FSM. Each cycle it is sampled high counts as one event.
- `evt_valid`, out, 1: head entry available.
- `evt_ready`, in, 1: reader accepts the head entry.
- `evt_ts`, out, `TS_W`: timestamp of the head entry.
- `evt_seq`, out, `SEQ_W`: sequence number of the head entry.
- `fifo_level`, out, $clog2(DEPTH)+1: number of occupied entries.
- `drop_count`, out, 8: saturating count of events dropped while the FIFO was full.

## Operation
- **Timestamp counter `ts`:** free-running; +1 every cycle; wraps from 2^TS_W−1 to 0.
- **Sequence counter `seq`:** +1 on every sampled event, whether accepted or dropped; wraps from 2^SEQ_W−1 to 0.
- **Event capture:** when `store_i`=1, the entry {`ts`, `seq`} uses the values present before that edge's increment.
- **Push:** occurs when `store_i`=1 and either the FIFO is not full, or it is full and a pop happens on the same edge.
- **Drop:** occurs when `store_i`=1, the FIFO is full and there is no pop. `drop_count` increments and saturates at 255; the entry is discarded.
- **Pop:** occurs when `evt_valid` and `evt_ready` are both 1 on an edge. The head advances.
- **Output hold:** `evt_ts` and `evt_seq` hold stable while `evt_valid`=1 and `evt_ready`=0.
- **Simultaneous push and pop:**
  - Level unchanged.
  - Push is accepted even when full.
  - With one entry, the new entry becomes head on the next cycle.
- **Pointers:** read and write pointers are `$clog2(DEPTH)` bits wide and wrap naturally. The full/empty decision uses `fifo_level`.
- **`evt_valid`:** equals `fifo_level != 0`. It is driven from registered state only.

## Timing
- **Reset values** (asynchronous on `rst_n`=0, regardless of activity):
  - `ts`=0, `seq`=0.
  - `fifo_level`=0, `evt_valid`=0.
  - `evt_ts`=0, `evt_seq`=0.
  - `drop_count`=0.
- **Reset mid-operation:** all queued entries are lost. The first event after release gets `seq`=0.
- **Latency:** when `store_i` is high at edge N into an empty FIFO, `evt_valid`=1 after edge N. No combinational bypass from `store_i` to outputs.
- **Throughput:** one push and one pop per cycle sustained.
- **Handshake:**
  - `evt_valid` never depends combinationally on `evt_ready`.
  - Once `evt_valid` is asserted, it stays high until the pop.
- **FIFO contents:** no reset is required on the data array; only pointers, level and counters are reset.

## Configuration
- **`STORE_LOG_DROP_CNT_EN` defined:** the `drop_count` register and saturation logic are present as described above.
- **Not defined:**
  - `drop_count` is tied to 0 and no register is inferred.
  - Drops still occur and are detectable only through `evt_seq` gaps.
  - All other behaviour is identical.

## Structure
- **Package `store_log_pkg`:**
  - `store_evt_t` packed struct {ts, seq}.
  - Default constants: `DEPTH`, `TS_W`, `SEQ_W`.
  - `DROP_SAT`=255.
- **Sub-module `store_log_fifo`:**
  - Synchronous single-clock FIFO of `store_evt_t` with push/pop/level.
  - Supports a simultaneous push when full together with a pop.
- **Top level:** contains the `ts` and `seq` counters, push/drop decision, drop counter, and `ifdef` block.

## Test plan
- **Reset then single event:** `store_i` pulse at cycle 5 after release → `evt_valid`=1 the next cycle with `evt_ts`=5, `evt_seq`=0; `fifo_level`=1. Pop → `fifo_level`=0, `evt_valid`=0.
- **Fill and overflow:** `evt_ready`=0 with 10 consecutive events (`DEPTH`=8) → `fifo_level`=8, `drop_count`=2. Drain → `evt_seq` values 0..7 in order; the next accepted event has `seq`=10.
- **Full with simultaneous push and pop:** full FIFO, `store_i`=1 and `evt_ready`=1 in the same cycle → `drop_count` unchanged, `fifo_level` stays 8, new entry appears last.
- **Back-pressure hold:** `evt_valid`=1 with `evt_ready` held 0 for 20 cycles while events arrive → `evt_ts` and `evt_seq` are constant throughout.
- **Wrap and saturation:**
  - Run to `ts`=0xFFFF; events at 0xFFFF and the next cycle → timestamps 0xFFFF then 0x0000.
  - Force 300 drops → `drop_count`=255; with the macro undefined, `drop_count`=0.
- **Asynchronous reset mid-stream:** `rst_n` low between edges while `fifo_level`=5 → immediately `evt_valid`=0 and `fifo_level`=0. After release, the first event has `evt_seq`=0.
